// File: rtl/mpe_feeder_if.sv
// mpe_feeder_if: job, weight-stream, fmap-stream and column-drive signals of mpe_feeder.
// Signals: i_start/i_num_vec (job), i_w_* / o_w_ready (serial weights),
// i_f_* / o_f_ready (fmap vectors), o_weight_en/o_weight (weight load),
// o_left_en/o_right_en/o_fmap (skewed drive), o_busy/o_done (status),
// o_stall_cnt only when MPE_FEEDER_PERF_EN is defined.
// slave = the feeder, master = the source driving it.
interface mpe_feeder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUMBER_PE = 9
);
  logic                             i_start;
  logic [15:0]                      i_num_vec;
  logic                             i_w_valid;
  logic [DATA_WIDTH-1:0]            i_w_data;
  logic                             o_w_ready;
  logic                             i_f_valid;
  logic [NUMBER_PE*DATA_WIDTH-1:0]  i_f_data;
  logic                             o_f_ready;
  logic                             o_weight_en;
  logic [NUMBER_PE*DATA_WIDTH-1:0]  o_weight;
  logic [NUMBER_PE-1:0]             o_left_en;
  logic [NUMBER_PE-1:0]             o_right_en;
  logic [NUMBER_PE*DATA_WIDTH-1:0]  o_fmap;
  logic                             o_busy;
  logic                             o_done;
`ifdef MPE_FEEDER_PERF_EN
  logic [31:0]                      o_stall_cnt;
`endif
  modport slave (
    input  i_start, i_num_vec, i_w_valid, i_w_data, i_f_valid, i_f_data,
    output o_w_ready, o_f_ready, o_weight_en, o_weight, o_left_en, o_right_en,
           o_fmap, o_busy, o_done
`ifdef MPE_FEEDER_PERF_EN
    , o_stall_cnt
`endif
  );
  modport master (
    output i_start, i_num_vec, i_w_valid, i_w_data, i_f_valid, i_f_data,
    input  o_w_ready, o_f_ready, o_weight_en, o_weight, o_left_en, o_right_en,
           o_fmap, o_busy, o_done
`ifdef MPE_FEEDER_PERF_EN
    , o_stall_cnt
`endif
  );
endinterface

// File: rtl/mpe_feeder.sv
// mpe_feeder: loads a PE column's weights serially, then streams fmap vectors with a one-cycle-per-lane skew.
// Ports: i_clk (rising edge), i_rest (sync active-high reset), bus (mpe_feeder_if.slave).
// Optional MPE_FEEDER_PERF_EN adds bus.o_stall_cnt, counting STREAM cycles without a vector.
module mpe_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int NUMBER_PE = 9
) (
  input logic         i_clk,
  input logic         i_rest,
  mpe_feeder_if.slave bus
);
  localparam int CW = $clog2(NUMBER_PE + 1);
  localparam int VW = NUMBER_PE * DATA_WIDTH;
  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_e;
  state_e                state_q, state_d;
  logic [15:0]           num_q, vcnt_q;
  logic [CW-1:0]         wcnt_q;
  logic [DATA_WIDTH-1:0] w_q [NUMBER_PE];
  logic [NUMBER_PE-1:0]  left_q, right_q;
  logic [VW-1:0]         stg_q [NUMBER_PE];
  logic                  start_acc, w_acc, f_acc, w_full, last_vec, empty;
  assign start_acc = state_q == IDLE && bus.i_start;
  assign w_full    = wcnt_q == CW'(NUMBER_PE);
  assign w_acc     = bus.o_w_ready && bus.i_w_valid;
  assign f_acc     = bus.o_f_ready && bus.i_f_valid;
  assign last_vec  = vcnt_q + 16'd1 == num_q;
  assign empty     = ~|{left_q, right_q};
  always_ff @(posedge i_clk) state_q <= i_rest ? IDLE : state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = bus.i_start ? LOAD_W : IDLE;
      LOAD_W:  state_d = !w_full ? LOAD_W : ~|num_q ? DONE : STREAM;
      STREAM:  state_d = f_acc && last_vec ? DRAIN : STREAM;
      DRAIN:   state_d = empty ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  // The full-count cycle in LOAD_W is the single weight_en cycle.
  always_comb begin
    bus.o_w_ready   = state_q == LOAD_W && !w_full;
    bus.o_weight_en = state_q == LOAD_W && w_full;
    bus.o_f_ready   = state_q == STREAM;
    bus.o_busy      = state_q != IDLE;
    bus.o_done      = state_q == DONE;
  end
  // Stage k of the skew chain holds the vector that lane k presents; a stage only
  // loads when its predecessor is valid, so lanes hold their data across bubbles.
  always_ff @(posedge i_clk) begin
    if (i_rest) begin
      num_q   <= '0;
      vcnt_q  <= '0;
      wcnt_q  <= '0;
      left_q  <= '0;
      right_q <= '0;
      for (int k = 0; k < NUMBER_PE; k++) begin
        w_q[k]   <= '0;
        stg_q[k] <= '0;
      end
    end else begin
      if (start_acc) begin
        num_q  <= bus.i_num_vec;
        vcnt_q <= '0;
        wcnt_q <= '0;
      end
      if (w_acc) wcnt_q <= wcnt_q + 1'b1;
      if (f_acc) vcnt_q <= vcnt_q + 16'd1;
      for (int k = 0; k < NUMBER_PE; k++)
        if (w_acc && wcnt_q == CW'(k)) w_q[k] <= bus.i_w_data;
      left_q[0] <= f_acc;
      if (f_acc) stg_q[0] <= bus.i_f_data;
      for (int k = 1; k < NUMBER_PE; k++) begin
        left_q[k] <= left_q[k-1];
        if (left_q[k-1]) stg_q[k] <= stg_q[k-1];
      end
      right_q <= left_q;
    end
  end
  always_comb begin
    bus.o_weight = '0;
    bus.o_fmap   = '0;
    for (int k = 0; k < NUMBER_PE; k++) begin
      bus.o_weight[k*DATA_WIDTH +: DATA_WIDTH] = w_q[k];
      bus.o_fmap[k*DATA_WIDTH +: DATA_WIDTH]   = stg_q[k][k*DATA_WIDTH +: DATA_WIDTH];
    end
  end
  assign bus.o_left_en  = left_q;
  assign bus.o_right_en = right_q;
`ifdef MPE_FEEDER_PERF_EN
  logic [31:0] stall_q;
  always_ff @(posedge i_clk) begin
    if (i_rest || start_acc) stall_q <= '0;
    else if (state_q == STREAM && !bus.i_f_valid && ~&stall_q) stall_q <= stall_q + 32'd1;
  end
  assign bus.o_stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_mpe_feeder.sv
// tb_mpe_feeder: randomized scoreboard bench for mpe_feeder using per-lane event-time expectations.
module tb_mpe_feeder;
  localparam int DW = 32;
  localparam int N = 9;
  localparam int W = N * DW;
  typedef struct {int c; logic [DW-1:0] d;} ev_t;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  mpe_feeder_if #(.DATA_WIDTH(DW), .NUMBER_PE(N)) b ();
  mpe_feeder #(.DATA_WIDTH(DW), .NUMBER_PE(N)) dut (.i_clk(clk), .i_rest(rst), .bus(b));
  ev_t           lq [N][$];
  int            rq [N][$];
  int            wq_c[$];
  logic [W-1:0]  wq_d[$];
  int            dq[$];
  logic [DW-1:0] last [N];
  logic [W-1:0]  wexp;
  ev_t           ev;
  int            cyc = 0, total = 0, bad = 0, done_cnt = 0;
  int            jnum = 0, jw = 0, jv = 0, sfrom = 0, stall_exp = 0, pend;
  bit            idle_m = 1, zchk = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [639:0] act, input logic [639:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        lq[k].delete();
        rq[k].delete();
        last[k] = '0;
      end
      wq_c.delete();
      wq_d.delete();
      dq.delete();
      idle_m = 1;
      zchk = 1;
      jw = 0;
      jv = 0;
      jnum = 0;
      stall_exp = 0;
    end else begin
      if (zchk) begin
        chk("reset_zero", {b.o_weight_en, b.o_left_en, b.o_right_en, b.o_fmap, b.o_weight,
                           b.o_w_ready, b.o_f_ready, b.o_busy, b.o_done}, '0);
`ifdef MPE_FEEDER_PERF_EN
        chk("reset_stall", b.o_stall_cnt, 0);
`endif
      end
      zchk = 0;
      chk("busy", b.o_busy, !idle_m);
      if (idle_m && b.i_start) begin
        idle_m = 0;
        jnum = int'(b.i_num_vec);
        jw = 0;
        jv = 0;
        stall_exp = 0;
        sfrom = 1 << 30;
      end
      if (!idle_m && jw == N && jv < jnum && cyc >= sfrom && !b.i_f_valid) stall_exp++;
      if (b.i_w_valid && b.o_w_ready) begin
        if (idle_m || jw >= N) chk("w_extra_ready", b.o_w_ready, 0);
        else begin
          wexp[jw*DW +: DW] = b.i_w_data;
          jw++;
          if (jw == N) begin
            wq_c.push_back(cyc + 1);
            wq_d.push_back(wexp);
            sfrom = cyc + 2;
            if (jnum == 0) dq.push_back(cyc + 2);
          end
        end
      end
      if (b.i_f_valid && b.o_f_ready) begin
        if (idle_m || jw < N || cyc < sfrom || jv >= jnum) chk("f_extra_ready", b.o_f_ready, 0);
        else begin
          jv++;
          for (int k = 0; k < N; k++) begin
            lq[k].push_back('{c: cyc + 1 + k, d: b.i_f_data[k*DW +: DW]});
            rq[k].push_back(cyc + 2 + k);
          end
          if (jv == jnum) dq.push_back(cyc + N + 3);
        end
      end
      for (int k = 0; k < N; k++) begin
        if (b.o_left_en[k]) begin
          if (lq[k].size() == 0) chk("left_unexp", b.o_left_en[k], 0);
          else begin
            ev = lq[k].pop_front();
            chk("left_cyc", cyc, ev.c);
            chk("left_data", b.o_fmap[k*DW +: DW], ev.d);
            last[k] = ev.d;
          end
        end else begin
          if (lq[k].size() != 0 && lq[k][0].c <= cyc) begin
            chk("left_miss", b.o_left_en[k], 1);
            lq[k].delete(0);
          end
          chk("lane_hold", b.o_fmap[k*DW +: DW], last[k]);
        end
        if (b.o_right_en[k]) begin
          if (rq[k].size() == 0) chk("right_unexp", b.o_right_en[k], 0);
          else chk("right_cyc", cyc, rq[k].pop_front());
        end else if (rq[k].size() != 0 && rq[k][0] <= cyc) begin
          chk("right_miss", b.o_right_en[k], 1);
          rq[k].delete(0);
        end
      end
      if (b.o_weight_en) begin
        if (wq_c.size() == 0) chk("wen_unexp", b.o_weight_en, 0);
        else begin
          chk("wen_cyc", cyc, wq_c.pop_front());
          chk("weight", b.o_weight, wq_d.pop_front());
        end
      end else if (wq_c.size() != 0 && wq_c[0] <= cyc) begin
        chk("wen_miss", b.o_weight_en, 1);
        wq_c.delete(0);
        wq_d.delete(0);
      end
      if (b.o_done) begin
        if (dq.size() == 0) chk("done_unexp", b.o_done, 0);
        else begin
          chk("done_cyc", cyc, dq.pop_front());
          done_cnt++;
          idle_m = 1;
        end
      end else if (dq.size() != 0 && dq[0] <= cyc) begin
        chk("done_miss", b.o_done, 1);
        dq.delete(0);
        done_cnt++;
        idle_m = 1;
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [W-1:0] mkvec(input bit dir);
    logic [W-1:0] v;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = dir ? DW'(10 + k) : $urandom;
    return v;
  endfunction
  task automatic wait_acc(input bit is_w);
    bit acc;
    int g;
    g = 0;
    do begin
      @(negedge clk);
      acc = is_w ? (b.i_w_valid && b.o_w_ready) : (b.i_f_valid && b.o_f_ready);
      tick();
      g++;
      if (!acc && g > 200) begin
        chk(is_w ? "w_timeout" : "f_timeout", is_w ? b.o_w_ready : b.o_f_ready, 1);
        acc = 1;
      end
    end while (!acc);
  endtask
  task automatic run_job(input int num, input int gfix, input int gmax, input bit glitch,
                         input bit rmid, input bit dir);
    int d0, g;
    d0 = done_cnt;
    b.i_start = 1;
    b.i_num_vec = num[15:0];
    tick();
    b.i_start = 0;
    b.i_num_vec = 16'($urandom);
    for (int n = 0; n < N; n++) begin
      if (gmax > 0) begin
        b.i_w_valid = 0;
        repeat ($urandom_range(0, 1)) tick();
      end
      b.i_w_valid = 1;
      b.i_w_data = dir ? DW'(n + 1) : $urandom;
      if (glitch && n == 3) begin
        b.i_start = 1;
        b.i_num_vec = 16'd7;
      end
      wait_acc(1);
      b.i_start = 0;
    end
    b.i_w_data = $urandom;
    b.i_f_valid = 1;
    b.i_f_data = mkvec(dir);
    for (int i = 0; i < num; i++) begin
      if (i > 0) begin
        g = gfix >= 0 ? gfix : $urandom_range(0, gmax);
        b.i_f_valid = 0;
        repeat (g) tick();
        b.i_f_valid = 1;
        b.i_f_data = mkvec(dir);
      end
      if (glitch && i == 1) b.i_start = 1;
      wait_acc(0);
      b.i_start = 0;
    end
    b.i_f_data = mkvec(0);
    if (rmid) begin
      repeat (2) tick();
      rst = 1;
      tick();
      rst = 0;
      return;
    end
    g = 0;
    while (done_cnt == d0 && g < 300) begin
      tick();
      g++;
    end
    chk("done_seen", done_cnt - d0, 1);
    chk("vec_count", jv, num);
    chk("w_count", jw, N);
`ifdef MPE_FEEDER_PERF_EN
    chk("stall_cnt", b.o_stall_cnt, stall_exp);
`endif
    repeat (2) tick();
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=hang want=finish", cyc);
    $fatal(1);
  end
  initial begin
    b.i_start = 0;
    b.i_num_vec = '0;
    b.i_w_valid = 0;
    b.i_w_data = '0;
    b.i_f_valid = 0;
    b.i_f_data = '0;
    repeat (3) tick();
    rst = 0;
    repeat (2) tick();
    run_job(1, 0, 0, 0, 0, 1);
    run_job(3, 0, 0, 0, 0, 0);
    run_job(2, 2, 0, 0, 0, 0);
    run_job(0, 0, 0, 0, 0, 0);
    run_job(3, 0, 0, 0, 1, 0);
    repeat (2) tick();
    run_job(2, -1, 2, 0, 0, 0);
    run_job(3, 1, 0, 1, 0, 0);
    for (int r = 0; r < 6; r++) run_job($urandom_range(0, 5), -1, 3, 0, 0, 0);
    b.i_w_valid = 0;
    b.i_f_valid = 0;
    repeat (5) tick();
    pend = wq_c.size() + dq.size();
    for (int k = 0; k < N; k++) pend += lq[k].size() + rq[k].size();
    chk("queues_empty", pend, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
